wb_skid_pipeline_reg: RTL and testbench
=======================================

Name: wb_skid_pipeline_reg

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Carries writeback controls (RegWrite, MemtoReg), ALU result, memory read data and destination register from the MEM stage to the WB stage.
- Supports back-pressure from WB and a synchronous flush.
- Sustains one transfer per cycle with no combinational path from out_ready to in_ready.
- Counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, width of ALU-result and memory-data payloads
RD_W, 5, width of destination register index
CNT_W, 16, width of saturating stall counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-low; sampled on rising edge of clk
flush  input  1  synchronous kill of all held entries
in_valid  input  1  MEM stage offers an entry
in_ready  output  1  stage can accept an entry this cycle
in_regwrite  input  1  RegWrite control of offered entry
in_memtoreg  input  1  MemtoReg control of offered entry
in_data_alu  input  DATA_W  ALU result
in_data_mem  input  DATA_W  memory read data
in_rd  input  RD_W  destination register
out_valid  output  1  head entry valid toward WB
out_ready  input  1  WB consumes head entry this cycle
out_regwrite  output  1  head RegWrite, gated by out_valid
out_memtoreg  output  1  head MemtoReg
out_data_alu  output  DATA_W  head ALU result
out_data_mem  output  DATA_W  head memory data
out_rd  output  RD_W  head destination register
occupancy  output  2  number of held entries, 0..2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage is a main register (drives out_*) plus a skid register, each holding {regwrite, memtoreg, data_alu, data_mem, rd} and a valid bit.
- Invariant: skid_valid=1 implies main_valid=1.
- in_ready = ~skid_valid. It depends only on flops.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = main_valid.
- out_regwrite = main_regwrite & main_valid. The other out_* are driven directly from main and hold their last value when invalid.
- occupancy = main_valid + skid_valid.
- Latency: an entry accepted into an empty stage appears on out_* the next cycle.
- Next state, when not flushing:
  - main empty: accept loads main.
  - main full, pop, skid empty: accept loads main; with no accept, main_valid is cleared.
  - main full, no pop, skid empty: accept loads skid.
  - main full, skid full, pop: skid moves to main and skid_valid is cleared. No accept is possible because in_ready=0.
  - main full, skid full, no pop: hold.
- Order is preserved at all times; no entry is duplicated or dropped.
- flush=1: main_valid and skid_valid are cleared next cycle. A same-cycle accept or pop is ignored. Payload flops are not cleared by flush.
- rst=0 (highest priority, overrides flush): on that clock edge all valid bits, all payload flops and stall_cnt go to 0.
  - After reset: out_valid=0, in_ready=1, occupancy=0, and all out_* are 0.
  - Reset mid-transfer discards held entries.
- stall_cnt increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
  - Unaffected by flush except through out_valid.
- in_valid with in_ready=0: the input is ignored. MEM holds its data; the block does not latch it.

Test Plan:
- Reset and single transfer: hold rst=0 for 2 cycles, then release. Expect out_valid=0, in_ready=1, occupancy=0, all out_*=0. Next, offer one entry {regwrite=1, memtoreg=0, data_alu=0x0000_00A5, rd=7} with out_ready=1. Expect it on out_* exactly 1 cycle later with out_valid=1, and out_valid=0 the cycle after.
- Streaming: send 8 back-to-back entries with data_alu=1..8, out_ready=1 throughout. Expect out_valid=1 for 8 consecutive cycles carrying 1..8 in order, in_ready constantly 1, stall_cnt=0.
- Back-pressure and skid: stream data_alu=1..4 while out_ready=0 from cycle 2. Expect occupancy to reach 2, in_ready=0, entry 3 held at the input. Release out_ready; expect outputs 1,2,3,4 in order with no loss, and stall_cnt equal to the number of stalled cycles.
- Flush: with occupancy=2, assert flush together with in_valid. Expect out_valid=0, occupancy=0, in_ready=1, out_regwrite=0 next cycle, and the flush-cycle input discarded.
- Stall counter saturation: with CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles. Expect stall_cnt to go 1..7 and stay at 7. Pulse rst=0; expect stall_cnt=0 on that edge.
- Reset mid-operation: with occupancy=2, drive rst=0 and flush=0 for one cycle. Expect all outputs 0, occupancy=0, in_ready=1 after the edge. A later new entry passes with 1-cycle latency.

Source files
------------

// File: rtl/wb_skid_pipeline_reg.sv
// wb_skid_pipeline_reg: MEM/WB pipeline stage with 2-entry skid buffer, flush and saturating stall counter
module wb_skid_pipeline_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [DATA_W-1:0] in_data_alu,
    input  logic [DATA_W-1:0] in_data_mem,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memtoreg,
    output logic [DATA_W-1:0] out_data_alu,
    output logic [DATA_W-1:0] out_data_mem,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int P_W = 2 + 2 * DATA_W + RD_W;

    logic [P_W-1:0]   main_q, main_d, skid_q, skid_d, in_pld;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept, pop;

    assign in_pld    = {in_regwrite, in_memtoreg, in_data_alu, in_data_mem, in_rd};
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign accept    = in_valid & in_ready;
    assign pop       = main_v_q & out_ready;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt = stall_q;
    assign {out_regwrite, out_memtoreg, out_data_alu, out_data_mem, out_rd} =
        {main_q[P_W-1] & main_v_q, main_q[P_W-2:0]};

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        stall_d  = (main_v_q & ~out_ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            main_v_d = accept;
            main_d   = accept ? in_pld : main_q;
        end else if (skid_v_q) begin
            main_d   = pop ? skid_q : main_q;
            skid_v_d = ~pop;
        end else if (pop) begin
            main_v_d = accept;
            main_d   = accept ? in_pld : main_q;
        end else begin
            skid_v_d = accept;
            skid_d   = accept ? in_pld : skid_q;
        end
    end

    // Reset also clears payload so out_* read as zero afterwards; flush leaves it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_skid_pipeline_reg.sv
// tb_wb_skid_pipeline_reg: scoreboard bench; a queue of held entries models the stage, a negedge monitor compares.
module tb_wb_skid_pipeline_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_regwrite, in_memtoreg, out_ready;
    logic [31:0] in_data_alu, in_data_mem;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, out_regwrite, out_memtoreg;
    logic [31:0] out_data_alu, out_data_mem;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        s_in_ready, s_out_valid, s_out_regwrite, s_out_memtoreg;
    logic [31:0] s_out_data_alu, s_out_data_mem;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt;

    always #5 clk = ~clk;

    wb_skid_pipeline_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_data_alu(in_data_alu),
        .in_data_mem(in_data_mem), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_data_alu(out_data_alu),
        .out_data_mem(out_data_mem), .out_rd(out_rd), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    wb_skid_pipeline_reg #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_data_alu(in_data_alu),
        .in_data_mem(in_data_mem), .in_rd(in_rd), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_regwrite(s_out_regwrite), .out_memtoreg(s_out_memtoreg), .out_data_alu(s_out_data_alu),
        .out_data_mem(s_out_data_mem), .out_rd(s_out_rd), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    ent_t        cur;
    int unsigned st16, st3;
    int          checks = 0, errors = 0;
    logic        run = 1'b0;
    logic        acc;

    // Reference: the stage is a FIFO of at most two entries; head is what WB sees.
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            last = '0;
            st16 = 0;
            st3  = 0;
        end else begin
            if (q.size() > 0 && !out_ready) begin
                if (st16 < 65535) st16++;
                if (st3 < 7) st3++;
            end
            if (flush) q.delete();
            else begin
                acc = in_valid && q.size() < 2;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back('{in_regwrite, in_memtoreg, in_data_alu, in_data_mem, in_rd});
            end
            if (q.size() > 0) last = q[0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("out_regwrite", 64'(out_regwrite), 64'(last.rw && q.size() > 0));
            chk("out_memtoreg", 64'(out_memtoreg), 64'(last.mr));
            chk("out_data_alu", 64'(out_data_alu), 64'(last.alu));
            chk("out_data_mem", 64'(out_data_mem), 64'(last.mem));
            chk("out_rd", 64'(out_rd), 64'(last.rd));
            chk("stall_cnt", 64'(stall_cnt), 64'(st16));
            chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(st3));
        end
    end

    task automatic drv(input logic v, input ent_t e, input logic ordy, input logic fl, input logic rs);
        in_valid    = v;
        in_regwrite = e.rw;
        in_memtoreg = e.mr;
        in_data_alu = e.alu;
        in_data_mem = e.mem;
        in_rd       = e.rd;
        out_ready   = ordy;
        flush       = fl;
        rst         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] alu, input logic ordy);
        ent_t e;
        e = '{1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom)};
        drv(v, e, ordy, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) put(1'b0, 32'h0, ordy);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_regwrite = 1'b0; in_memtoreg = 1'b0; in_data_alu = '0; in_data_mem = '0; in_rd = '0;
        @(posedge clk);
        #1;
        run = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        cur = '{1'b1, 1'b0, 32'h0000_00A5, 32'h0, 5'd7};
        drv(1'b1, cur, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        for (int i = 1; i <= 8; i++) put(1'b1, i, 1'b1);
        idle(3, 1'b1);
        put(1'b1, 1, 1'b1);
        put(1'b1, 2, 1'b0);
        for (int i = 0; i < 3; i++) put(1'b1, 3, 1'b0);
        put(1'b1, 3, 1'b1);
        put(1'b1, 3, 1'b1);
        put(1'b1, 4, 1'b1);
        idle(4, 1'b1);
        put(1'b1, 32'h11, 1'b0);
        put(1'b1, 32'h22, 1'b0);
        cur = '{1'b1, 1'b1, 32'h33, 32'h44, 5'd9};
        drv(1'b1, cur, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        put(1'b1, 32'h55, 1'b0);
        idle(10, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        put(1'b1, 32'h66, 1'b0);
        put(1'b1, 32'h77, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h88, 1'b1);
        idle(3, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cur = '{1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom)};
            drv($urandom_range(0, 9) < 7, cur, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0);
        end
        idle(4, 1'b1);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
